// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the I2C register-file target.
package i2c_slave_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RACK_CHK,
        ST_WAIT_STOP
    } i2c_slv_st_t;

    localparam int   I2C_SYNC_STAGES = 2;
    localparam logic I2C_RW_READ     = 1'b1;

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer followed by a registered rise/fall detector.
// level is delayed to line up with the rise/fall pulses.
module i2c_sync_edge
    import i2c_slave_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [I2C_SYNC_STAGES-1:0] sync_q;
    logic                       prev_q;

    // Idle bus lines are high, so reset to 1 to avoid a spurious edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
            prev_q <= 1'b1;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[I2C_SYNC_STAGES-2:0], d};
            prev_q <= sync_q[I2C_SYNC_STAGES-1];
            rise   <= sync_q[I2C_SYNC_STAGES-1] & ~prev_q;
            fall   <= ~sync_q[I2C_SYNC_STAGES-1] & prev_q;
        end
    end

    assign level = prev_q;

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C target answering one 7-bit address with an auto-incrementing byte
// register file; every register write is mirrored on a one-cycle strobe.
module i2c_slave_regs
    import i2c_slave_pkg::*;
#(
    parameter logic [6:0] ADDR  = 7'h50,
    parameter int         DEPTH = 16,
    parameter int         AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          scl_i,
    output logic          scl_o,
    output logic          scl_t,
    input  logic          sda_i,
    output logic          sda_o,
    output logic          sda_t,
    output logic          wr_valid_o,
    output logic [AW-1:0] wr_addr_o,
    output logic [7:0]    wr_data_o,
    output logic          busy_o,
    output logic [3:0]    dbg_state
);

    localparam logic [AW-1:0] PTR_ONE = 1;

    i2c_slv_st_t   state, state_n;
    logic [2:0]    cnt, cnt_n;
    logic [7:0]    sh, sh_n;
    logic [AW-1:0] ptr, ptr_n;
    logic          sda_t_n, busy_n, wr_en;
    logic [7:0]    regs [DEPTH];
    logic [7:0]    byte_in, rd_byte;
    logic          scl_lvl, scl_rise, scl_fall;
    logic          sda_lvl, sda_rise, sda_fall;
    logic          start, stop;

    i2c_sync_edge u_scl (.clk(clk), .rst(rst), .d(scl_i),
                         .level(scl_lvl), .rise(scl_rise), .fall(scl_fall));
    i2c_sync_edge u_sda (.clk(clk), .rst(rst), .d(sda_i),
                         .level(sda_lvl), .rise(sda_rise), .fall(sda_fall));

    assign start     = sda_fall & scl_lvl;
    assign stop      = sda_rise & scl_lvl;
    assign byte_in   = {sh[6:0], sda_lvl};
    assign rd_byte   = regs[ptr];
    assign scl_o     = 1'b0;
    assign scl_t     = 1'b1;
    assign sda_o     = 1'b0;
    assign dbg_state = state;

    // ACK states use cnt as a phase flag: 0 = waiting for the fall that
    // starts the ACK, 1 = waiting for the fall that ends it.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sh_n    = sh;
        ptr_n   = ptr;
        sda_t_n = sda_t;
        wr_en   = 1'b0;
        if (start) begin
            state_n = ST_ADDR;
            cnt_n   = '0;
            sda_t_n = 1'b1;
        end else if (stop) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
            sda_t_n = 1'b1;
        end else begin
            case (state)
                ST_ADDR, ST_PTR, ST_WDATA: begin
                    if (scl_rise) begin
                        sh_n  = byte_in;
                        cnt_n = cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            cnt_n = '0;
                            if (state == ST_ADDR) begin
                                state_n = (byte_in[7:1] == ADDR) ? ST_ADDR_ACK : ST_WAIT_STOP;
                            end else if (state == ST_PTR) begin
                                ptr_n   = byte_in[AW-1:0];
                                state_n = ST_PTR_ACK;
                            end else begin
                                wr_en   = 1'b1;
                                ptr_n   = ptr + PTR_ONE;
                                state_n = ST_WDATA_ACK;
                            end
                        end
                    end
                end
                ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
                    if (scl_fall) begin
                        if (cnt == 3'd0) begin
                            sda_t_n = 1'b0;
                            cnt_n   = 3'd1;
                        end else begin
                            cnt_n   = '0;
                            sda_t_n = 1'b1;
                            if (state != ST_ADDR_ACK) begin
                                state_n = ST_WDATA;
                            end else if (sh[0] == I2C_RW_READ) begin
                                state_n = ST_RDATA;
                                sh_n    = rd_byte;
                                sda_t_n = rd_byte[7];
                            end else begin
                                state_n = ST_PTR;
                            end
                        end
                    end
                end
                ST_RDATA: begin
                    if (scl_fall) begin
                        sh_n    = {sh[6:0], sh[7]};
                        sda_t_n = sh[6];
                    end else if (scl_rise) begin
                        cnt_n = cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            cnt_n   = '0;
                            ptr_n   = ptr + PTR_ONE;
                            state_n = ST_RACK_CHK;
                        end
                    end
                end
                ST_RACK_CHK: begin
                    if (scl_rise) begin
                        if (sda_lvl) begin
                            state_n = ST_WAIT_STOP;
                            sda_t_n = 1'b1;
                        end else begin
                            cnt_n = 3'd1;
                        end
                    end else if (scl_fall) begin
                        if (cnt == 3'd1) begin
                            cnt_n   = '0;
                            state_n = ST_RDATA;
                            sh_n    = rd_byte;
                            sda_t_n = rd_byte[7];
                        end else begin
                            sda_t_n = 1'b1;
                        end
                    end
                end
                ST_WAIT_STOP: sda_t_n = 1'b1;
                default: ;
            endcase
        end

        busy_n = busy_o;
        if (state_n == ST_ADDR_ACK) begin
            busy_n = 1'b1;
        end else if (state_n == ST_IDLE || state_n == ST_WAIT_STOP) begin
            busy_n = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            sh         <= '0;
            ptr        <= '0;
            sda_t      <= 1'b1;
            busy_o     <= 1'b0;
            wr_valid_o <= 1'b0;
            wr_addr_o  <= '0;
            wr_data_o  <= '0;
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            sh         <= sh_n;
            ptr        <= ptr_n;
            sda_t      <= sda_t_n;
            busy_o     <= busy_n;
            wr_valid_o <= wr_en;
            if (wr_en) begin
                regs[ptr] <= byte_in;
                wr_addr_o <= ptr;
                wr_data_o <= byte_in;
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Bit-banged I2C master driving i2c_slave_regs from a table of bus operations.
module tb_i2c_slave_regs;
    import i2c_slave_pkg::*;

    localparam int Q  = 8;
    localparam int AW = 4;

    localparam logic [1:0] K_START = 2'd0;
    localparam logic [1:0] K_STOP  = 2'd1;
    localparam logic [1:0] K_WR    = 2'd2;
    localparam logic [1:0] K_RD    = 2'd3;

    typedef struct {
        logic [1:0]    kind;
        logic [7:0]    data;   // byte to send, or bit0 = NACK for reads
        logic [7:0]    expv;   // expected ACK (bit0) or read byte
        logic          wr;     // a register write strobe is expected
        logic [AW-1:0] waddr;
        logic          busy;   // busy_o after the operation
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scl_m = 1'b1, sda_m = 1'b1;
    logic scl_i, sda_i;
    logic scl_o, scl_t, sda_o, sda_t;
    logic wr_valid_o, busy_o;
    logic [AW-1:0] wr_addr_o;
    logic [7:0] wr_data_o;
    logic [3:0] dbg_state;

    int checks = 0, passes = 0;
    int cyc = 0, rise8_cyc = 0;
    logic wv_prev = 1'b0, busy_seen = 1'b0, sda_low_seen = 1'b0;
    logic [AW+7:0] exp_q[$];
    logic [AW+7:0] got_q[$];
    vec_t tbl[33];

    assign scl_i = scl_m & (scl_t | scl_o);
    assign sda_i = sda_m & (sda_t | sda_o);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    i2c_slave_regs #(.ADDR(7'h50), .DEPTH(16)) dut (
        .clk(clk), .rst(rst),
        .scl_i(scl_i), .scl_o(scl_o), .scl_t(scl_t),
        .sda_i(sda_i), .sda_o(sda_o), .sda_t(sda_t),
        .wr_valid_o(wr_valid_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
        .busy_o(busy_o), .dbg_state(dbg_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (wr_valid_o) begin
            got_q.push_back({wr_addr_o, wr_data_o});
            check("wr_latency", cyc - rise8_cyc, 4);
            check("wr_pulse_width", {31'd0, wv_prev}, 0);
        end
        wv_prev = wr_valid_o;
        if (busy_o) busy_seen = 1'b1;
        if (!sda_t) sda_low_seen = 1'b1;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_bit(input logic b, input logic mark);
        sda_m = b;
        wait_clk(Q);
        scl_m = 1'b1;
        if (mark) rise8_cyc = cyc;
        wait_clk(Q);
        scl_m = 1'b0;
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1;
        wait_clk(Q);
        scl_m = 1'b1;
        wait_clk(Q / 2);
        b = sda_i;
        wait_clk(Q / 2);
        scl_m = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) write_bit(d[i], i == 0);
        read_bit(b);
        ack = ~b;
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        for (int i = 7; i >= 0; i--) read_bit(d[i]);
        write_bit(nack, 1'b0);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        wait_clk(Q);
        scl_m = 1'b1;
        wait_clk(Q);
        sda_m = 1'b0;
        wait_clk(Q);
        scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0;
        wait_clk(Q);
        scl_m = 1'b1;
        wait_clk(Q);
        sda_m = 1'b1;
        wait_clk(Q);
    endtask

    function automatic vec_t mk(input logic [1:0] k, input logic [7:0] d, input logic [7:0] e,
                                input logic w, input logic [AW-1:0] a, input logic b);
        vec_t v;
        v.kind = k; v.data = d; v.expv = e; v.wr = w; v.waddr = a; v.busy = b;
        return v;
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        logic       ack;
        logic [7:0] d;
        case (v.kind)
            K_START: i2c_start();
            K_STOP:  i2c_stop();
            K_WR: begin
                send_byte(v.data, ack);
                check($sformatf("ack[%0d]", idx), {31'd0, ack}, {31'd0, v.expv[0]});
                if (v.wr) exp_q.push_back({v.waddr, v.data});
                check($sformatf("wr_count[%0d]", idx), got_q.size(), exp_q.size());
                while (got_q.size() > 0 && exp_q.size() > 0)
                    check($sformatf("wr_beat[%0d]", idx), {20'd0, got_q.pop_front()},
                          {20'd0, exp_q.pop_front()});
                got_q.delete();
                exp_q.delete();
            end
            default: begin
                read_byte(v.data[0], d);
                check($sformatf("rd_data[%0d]", idx), {24'd0, d}, {24'd0, v.expv});
                if (v.data[0]) check($sformatf("nack_release[%0d]", idx), {31'd0, sda_t}, 1);
            end
        endcase
        check($sformatf("busy[%0d]", idx), {31'd0, busy_o}, {31'd0, v.busy});
    endtask

    initial begin
        logic b;
        // write 11,22 at 3; random read back; wrap at 15; pointer masking
        tbl[0]  = mk(K_START, 8'h00, 8'h00, 0, 0, 0);
        tbl[1]  = mk(K_WR,    8'hA0, 8'h01, 0, 0, 1);
        tbl[2]  = mk(K_WR,    8'h03, 8'h01, 0, 0, 1);
        tbl[3]  = mk(K_WR,    8'h11, 8'h01, 1, 3, 1);
        tbl[4]  = mk(K_WR,    8'h22, 8'h01, 1, 4, 1);
        tbl[5]  = mk(K_STOP,  8'h00, 8'h00, 0, 0, 0);
        tbl[6]  = mk(K_START, 8'h00, 8'h00, 0, 0, 0);
        tbl[7]  = mk(K_WR,    8'hA0, 8'h01, 0, 0, 1);
        tbl[8]  = mk(K_WR,    8'h03, 8'h01, 0, 0, 1);
        tbl[9]  = mk(K_START, 8'h00, 8'h00, 0, 0, 1);
        tbl[10] = mk(K_WR,    8'hA1, 8'h01, 0, 0, 1);
        tbl[11] = mk(K_RD,    8'h00, 8'h11, 0, 0, 1);
        tbl[12] = mk(K_RD,    8'h01, 8'h22, 0, 0, 0);
        tbl[13] = mk(K_STOP,  8'h00, 8'h00, 0, 0, 0);
        tbl[14] = mk(K_START, 8'h00, 8'h00, 0, 0, 0);
        tbl[15] = mk(K_WR,    8'hA0, 8'h01, 0, 0, 1);
        tbl[16] = mk(K_WR,    8'h0F, 8'h01, 0, 0, 1);
        tbl[17] = mk(K_WR,    8'hAA, 8'h01, 1, 15, 1);
        tbl[18] = mk(K_WR,    8'hBB, 8'h01, 1, 0, 1);
        tbl[19] = mk(K_STOP,  8'h00, 8'h00, 0, 0, 0);
        tbl[20] = mk(K_START, 8'h00, 8'h00, 0, 0, 0);
        tbl[21] = mk(K_WR,    8'hA0, 8'h01, 0, 0, 1);
        tbl[22] = mk(K_WR,    8'h0F, 8'h01, 0, 0, 1);
        tbl[23] = mk(K_START, 8'h00, 8'h00, 0, 0, 1);
        tbl[24] = mk(K_WR,    8'hA1, 8'h01, 0, 0, 1);
        tbl[25] = mk(K_RD,    8'h00, 8'hAA, 0, 0, 1);
        tbl[26] = mk(K_RD,    8'h01, 8'hBB, 0, 0, 0);
        tbl[27] = mk(K_STOP,  8'h00, 8'h00, 0, 0, 0);
        tbl[28] = mk(K_START, 8'h00, 8'h00, 0, 0, 0);
        tbl[29] = mk(K_WR,    8'hA0, 8'h01, 0, 0, 1);
        tbl[30] = mk(K_WR,    8'h13, 8'h01, 0, 0, 1);
        tbl[31] = mk(K_WR,    8'h5C, 8'h01, 1, 3, 1);
        tbl[32] = mk(K_STOP,  8'h00, 8'h00, 0, 0, 0);

        wait_clk(3);
        check("rst_sda_t", {31'd0, sda_t}, 1);
        check("rst_scl_t", {31'd0, scl_t}, 1);
        check("rst_scl_o", {31'd0, scl_o}, 0);
        check("rst_sda_o", {31'd0, sda_o}, 0);
        check("rst_busy", {31'd0, busy_o}, 0);
        check("rst_wr_valid", {31'd0, wr_valid_o}, 0);
        check("rst_wr_addr", {28'd0, wr_addr_o}, 0);
        check("rst_wr_data", {24'd0, wr_data_o}, 0);
        check("rst_state", {28'd0, dbg_state}, ST_IDLE);
        rst = 1'b0;
        wait_clk(4);

        for (int i = 0; i < 33; i++) run_vec(i, tbl[i]);

        // Address mismatch: no ACK, no write, busy never rises
        busy_seen = 1'b0;
        sda_low_seen = 1'b0;
        run_vec(100, mk(K_START, 8'h00, 8'h00, 0, 0, 0));
        run_vec(101, mk(K_WR,    8'hA4, 8'h00, 0, 0, 0));
        check("mm_state", {28'd0, dbg_state}, ST_WAIT_STOP);
        run_vec(102, mk(K_WR,    8'h55, 8'h00, 0, 0, 0));
        run_vec(103, mk(K_STOP,  8'h00, 8'h00, 0, 0, 0));
        check("mm_busy_seen", {31'd0, busy_seen}, 0);
        check("mm_sda_low_seen", {31'd0, sda_low_seen}, 0);

        // Reset in the middle of reading reg[0] = 8'hBB
        run_vec(200, mk(K_START, 8'h00, 8'h00, 0, 0, 0));
        run_vec(201, mk(K_WR,    8'hA0, 8'h01, 0, 0, 1));
        run_vec(202, mk(K_WR,    8'h00, 8'h01, 0, 0, 1));
        run_vec(203, mk(K_START, 8'h00, 8'h00, 0, 0, 1));
        run_vec(204, mk(K_WR,    8'hA1, 8'h01, 0, 0, 1));
        read_bit(b);
        check("mid_bit7", {31'd0, b}, 1);
        wait_clk(6);
        check("mid_drive_low", {31'd0, sda_t}, 0);
        rst = 1'b1;
        wait_clk(1);
        check("mid_rst_release", {31'd0, sda_t}, 1);
        check("mid_rst_busy", {31'd0, busy_o}, 0);
        wait_clk(2);
        rst = 1'b0;
        wait_clk(2);
        i2c_stop();
        run_vec(210, mk(K_START, 8'h00, 8'h00, 0, 0, 0));
        run_vec(211, mk(K_WR,    8'hA0, 8'h01, 0, 0, 1));
        run_vec(212, mk(K_WR,    8'h00, 8'h01, 0, 0, 1));
        run_vec(213, mk(K_START, 8'h00, 8'h00, 0, 0, 1));
        run_vec(214, mk(K_WR,    8'hA1, 8'h01, 0, 0, 1));
        run_vec(215, mk(K_RD,    8'h01, 8'h00, 0, 0, 0));
        run_vec(216, mk(K_STOP,  8'h00, 8'h00, 0, 0, 0));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/i2c_slave_regs.md
# i2c_slave_regs

Synthesizable I2C target with a small register file. It is the downstream stage of `i2c_master_wbs_8`: it sits on the shared SCL/SDA lines, answers one 7-bit address, and gives the master an auto-incrementing byte register file. Every register write is also mirrored on a one-cycle strobe port, so benches and surrounding logic can observe writes.

## Interface
- `ADDR`, 7'h50: 7-bit target address.
- `DEPTH`, 16: number of 8-bit registers; power of 2, range 2..256.
- `AW`, $clog2(DEPTH): pointer width (derived).

Ports:
- `clk`  in  1  system clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `scl_i`  in  1  SCL line sample (asynchronous).
- `scl_o`  out  1  constant 0.
- `scl_t`  out  1  constant 1; the block never stretches the clock.
- `sda_i`  in  1  SDA line sample (asynchronous).
- `sda_o`  out  1  constant 0.
- `sda_t`  out  1  1 = release SDA, 0 = pull SDA low.
- `wr_valid_o`  out  1  one-cycle pulse per register written.
- `wr_addr_o`  out  AW  register index written.
- `wr_data_o`  out  8  byte written.
- `busy_o`  out  1  high from an address-matched START until STOP or NACK-exit.

## Operation
- **Input conditioning:** `scl_i` and `sda_i` each go through a 2-flop synchronizer, then a 1-cycle edge register.
  - START: SDA fall while SCL high.
  - STOP: SDA rise while SCL high.
- **Bit timing:**
  - Bits are sampled on SCL rise.
  - `sda_t` changes only on the cycle after a detected SCL fall.
- **States:** IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK_CHK, WAIT_STOP.
- **IDLE:** START → ADDR, bit counter = 0.
- **ADDR:** shift 8 bits MSB first.
  - Upper 7 bits == `ADDR` → ADDR_ACK.
  - Otherwise → WAIT_STOP, SDA released.
- **ADDR_ACK:** pull SDA low for one SCL period.
  - R/W=0 → PTR.
  - R/W=1 → RDATA, first data bit driven at the ACK-ending SCL fall.
- **PTR → PTR_ACK:** ptr ← received byte & (DEPTH-1), ACK, then → WDATA.
- **WDATA → WDATA_ACK:**
  - On the 8th SCL rise: reg[ptr] ← byte, `wr_valid_o` pulses, ptr ← ptr+1 modulo DEPTH.
  - ACK, then → WDATA.
- **RDATA:**
  - Shift out reg[ptr], MSB first; a 1 bit is emitted by releasing SDA.
  - After the 8th bit: ptr ← ptr+1 (wraps), → RACK_CHK.
- **RACK_CHK:** sample the master bit on SCL rise.
  - 0 (ACK) → RDATA.
  - 1 (NACK) → WAIT_STOP.
- **WAIT_STOP:** SDA released; wait for STOP or START.
- **START/STOP priority:**
  - START in any state → ADDR (repeated start); ptr is kept.
  - STOP in any state → IDLE.
  - Both take priority over bit handling in the same cycle.
- **Reset values:**
  - `rst`: state IDLE, ptr 0, all registers 8'h00, `sda_t`=1, `wr_valid_o`=0, `wr_addr_o`=0, `wr_data_o`=0, `busy_o`=0.
  - Reset asserted mid-transfer releases SDA on the next clock.

## Timing
- SCL high and low phases must each be ≥ 4 `clk` periods. Shorter phases are out of spec and behaviour is undefined.
- Line change to internal event latency: 3 clk (2 synchronizer + 1 edge).
- `sda_t` update: 4 clk after the physical SCL fall. This must land inside the SCL low phase.
- `wr_valid_o`: asserted exactly 1 clk, 4 clk after the physical 8th SCL rise of a data byte. The pointer byte never pulses it.
- `busy_o`:
  - rises the cycle ADDR_ACK is entered;
  - falls the cycle IDLE or WAIT_STOP is entered.

## Structure
- **Package `i2c_slave_pkg`:**
  - state enum `i2c_slv_st_t`;
  - `I2C_SYNC_STAGES` = 2;
  - `I2C_RW_READ` = 1'b1.
- **Sub-module `i2c_sync_edge`:** synchronizer plus rise/fall detect, instantiated for SCL and for SDA.
- **Top:** FSM, bit counter, shift register, pointer, register array.

## Test plan
- **Write, auto-increment:** START, 8'hA0, 8'h03, 8'h11, 8'h22, STOP.
  - ACK on all 4 bytes.
  - `wr_valid_o` pulses twice: (3, 8'h11) then (4, 8'h22).
- **Random read:** START, 8'hA0, 8'h03, repeated START, 8'hA1, read 2 bytes (ACK, then NACK), STOP.
  - Slave returns 8'h11, 8'h22.
  - SDA released after the NACK.
- **Address mismatch:** START, 8'hA4, 8'h55, STOP.
  - No ACK (SDA stays high).
  - No `wr_valid_o`.
  - `busy_o` stays 0.
- **Wrap-around:** write 8'h0F, then data 8'hAA, 8'hBB.
  - Writes land at 15, then 0.
  - A read from pointer 15 returns AA, BB.
- **Reset mid-transfer:** assert `rst` during the RDATA of a read.
  - `sda_t`=1 on the next clk.
  - After release, a read from pointer 0 returns 8'h00.
- **Pointer masking:** pointer byte 8'h13 with DEPTH=16.
  - Next write pulses `wr_addr_o`=3.
